// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SERVE_INSTR = 2'd1,
    SERVE_DATA  = 2'd2
  } arb_state_e;

  localparam logic [1:0] BYTESEL_WORD = 2'b11;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction and a data requester onto one memory port.
// Data has priority unless the instruction side has been starved for STARVE_LIMIT data grants.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | no grant; arbitrate between pending requests
// SERVE_INSTR | instruction requester owns the memory port until q_m_ack
// SERVE_DATA  | data requester owns the memory port until q_m_ack
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic [15:0] instr_m_data_in,
  output logic        instr_m_ack,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic [15:0] data_m_data_in,
  output logic        data_m_ack,
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  input  logic [15:0] q_m_data_in,
  input  logic        q_m_ack
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  arb_state_e    state, state_next;
  logic [SW-1:0] streak, streak_next;
  logic          instr_starved;

  assign instr_starved = instr_m_access && (streak == STREAK_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
    end
  end

  always_comb begin
    state_next  = state;
    streak_next = streak;
    case (state)
      IDLE: begin
        if (!instr_m_access)
          streak_next = '0;
        if (data_m_access && !instr_starved) begin
          state_next = SERVE_DATA;
        end else if (instr_m_access) begin
          state_next  = SERVE_INSTR;
          streak_next = '0;
        end
      end
      SERVE_INSTR: begin
        if (q_m_ack)
          state_next = IDLE;
      end
      SERVE_DATA: begin
        if (q_m_ack) begin
          state_next = IDLE;
          // Only a waiting instruction request makes a data grant count as starvation.
          if (instr_m_access && (streak != STREAK_MAX))
            streak_next = streak + SW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // An ack arriving in the same cycle as reset belongs to an aborted transaction.
  always_comb begin
    q_m_addr        = '0;
    q_m_data_out    = '0;
    q_m_access      = 1'b0;
    q_m_wr_en       = 1'b0;
    q_m_bytesel     = '0;
    instr_m_data_in = '0;
    instr_m_ack     = 1'b0;
    data_m_data_in  = '0;
    data_m_ack      = 1'b0;
    case (state)
      SERVE_INSTR: begin
        q_m_addr        = instr_m_addr;
        q_m_access      = 1'b1;
        q_m_bytesel     = BYTESEL_WORD;
        instr_m_data_in = q_m_data_in;
        instr_m_ack     = q_m_ack && !reset;
      end
      SERVE_DATA: begin
        q_m_addr       = data_m_addr;
        q_m_data_out   = data_m_data_out;
        q_m_access     = 1'b1;
        q_m_wr_en      = data_m_wr_en;
        q_m_bytesel    = data_m_bytesel;
        data_m_data_in = q_m_data_in;
        data_m_ack     = q_m_ack && !reset;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level owner/streak model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] instr_m_addr;
  logic        instr_m_access;
  logic [15:0] instr_m_data_in;
  logic        instr_m_ack;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic [15:0] data_m_data_in;
  logic        data_m_ack;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic [15:0] q_m_data_in;
  logic        q_m_ack;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_data_in(instr_m_data_in), .instr_m_ack(instr_m_ack),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .data_m_data_in(data_m_data_in),
    .data_m_ack(data_m_ack),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
    .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
    .q_m_data_in(q_m_data_in), .q_m_ack(q_m_ack)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: who owns the port ("none", "instr", "data") and how many data grants starved instr.
  string owner = "none";
  int    starve_cnt = 0;

  int n_iack, n_dack;
  logic        s_acc, s_wr, s_iack, s_dack;
  logic [1:0]  s_bsel;
  logic [15:0] s_wdata, s_idin, s_ddin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    bit is_i, is_d;
    is_i = (owner == "instr");
    is_d = (owner == "data");
    chk("q_m_access", 32'(q_m_access), 32'(is_i || is_d));
    chk("q_m_addr", 32'(q_m_addr), is_i ? 32'(instr_m_addr) : is_d ? 32'(data_m_addr) : 32'd0);
    chk("q_m_data_out", 32'(q_m_data_out), is_d ? 32'(data_m_data_out) : 32'd0);
    chk("q_m_wr_en", 32'(q_m_wr_en), is_d ? 32'(data_m_wr_en) : 32'd0);
    chk("q_m_bytesel", 32'(q_m_bytesel), is_i ? 32'd3 : is_d ? 32'(data_m_bytesel) : 32'd0);
    chk("instr_m_ack", 32'(instr_m_ack), 32'(is_i && q_m_ack && !reset));
    chk("data_m_ack", 32'(data_m_ack), 32'(is_d && q_m_ack && !reset));
    chk("instr_m_data_in", 32'(instr_m_data_in), is_i ? 32'(q_m_data_in) : 32'd0);
    chk("data_m_data_in", 32'(data_m_data_in), is_d ? 32'(q_m_data_in) : 32'd0);
    s_acc = q_m_access; s_wr = q_m_wr_en; s_bsel = q_m_bytesel; s_wdata = q_m_data_out;
    s_iack = instr_m_ack; s_dack = data_m_ack; s_idin = instr_m_data_in; s_ddin = data_m_data_in;
    n_iack += int'(instr_m_ack);
    n_dack += int'(data_m_ack);
  endtask

  // Advance the model by one clock using the rules: decide only when nobody owns the port.
  task automatic model_edge();
    if (reset) begin
      owner = "none";
      starve_cnt = 0;
    end else if (owner == "none") begin
      if (!instr_m_access) starve_cnt = 0;
      if (data_m_access && !(instr_m_access && starve_cnt == LIMIT)) owner = "data";
      else if (instr_m_access) begin
        owner = "instr";
        starve_cnt = 0;
      end
    end else if (q_m_ack) begin
      if (owner == "data" && instr_m_access) starve_cnt = (starve_cnt < LIMIT) ? starve_cnt + 1 : LIMIT;
      owner = "none";
    end
  endtask

  task automatic cycle();
    #2;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    instr_m_addr = '0; instr_m_access = 0;
    data_m_addr = '0; data_m_data_out = '0; data_m_access = 0;
    data_m_wr_en = 0; data_m_bytesel = '0;
    q_m_data_in = '0; q_m_ack = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    @(posedge clk); model_edge(); #1;
    cycle();
    chk("reset_access", 32'(s_acc), 32'd0);

    // Instruction-only read, ack on third serve cycle.
    reset = 0; n_iack = 0; n_dack = 0;
    instr_m_access = 1; instr_m_addr = 19'h00100;
    cycle();
    chk("instr_idle_before_grant", 32'(s_acc), 32'd0);
    cycle();
    chk("instr_grant_n1", 32'(s_acc), 32'd1);
    chk("instr_bytesel", 32'(s_bsel), 32'd3);
    cycle();
    q_m_ack = 1;
    cycle();
    instr_m_access = 0; q_m_ack = 0;
    cycle();
    chk("instr_ack_count", 32'(n_iack), 32'd1);
    chk("instr_no_data_ack", 32'(n_dack), 32'd0);

    // Simultaneous requests with no starvation: data write first, dead cycle, then instr.
    n_iack = 0; n_dack = 0;
    instr_m_access = 1; instr_m_addr = 19'h00200;
    data_m_access = 1; data_m_addr = 19'h05555; data_m_wr_en = 1;
    data_m_data_out = 16'hBEEF; data_m_bytesel = 2'b01;
    cycle();
    q_m_ack = 1;
    cycle();
    chk("both_data_first", 32'(s_dack), 32'd1);
    chk("both_wdata", 32'(s_wdata), 32'hBEEF);
    chk("both_bytesel", 32'(s_bsel), 32'd1);
    chk("both_wr_en", 32'(s_wr), 32'd1);
    data_m_access = 0; q_m_ack = 0;
    cycle();
    chk("both_dead_cycle", 32'(s_acc), 32'd0);
    q_m_ack = 1;
    cycle();
    chk("both_then_instr", 32'(s_iack), 32'd1);
    instr_m_access = 0; q_m_ack = 0;
    cycle();

    // Back-to-back data with instr held: starvation limit lets instr in after LIMIT grants.
    n_iack = 0; n_dack = 0;
    instr_m_access = 1; data_m_access = 1; data_m_wr_en = 0; q_m_ack = 1;
    for (int i = 0; i < 40 && n_iack == 0; i++) cycle();
    chk("starve_data_grants", 32'(n_dack), 32'(LIMIT));
    chk("starve_instr_granted", 32'(n_iack), 32'd1);
    cycle();
    cycle();
    chk("starve_counter_cleared", 32'(s_dack), 32'd1);
    instr_m_access = 0; data_m_access = 0; q_m_ack = 0;
    cycle();

    // Reset in the middle of a data transaction aborts it without an ack.
    n_dack = 0;
    data_m_access = 1;
    cycle();
    cycle();
    chk("rst_mid_serving", 32'(s_acc), 32'd1);
    reset = 1; q_m_ack = 1;
    cycle();
    chk("rst_no_ack", 32'(s_dack), 32'd0);
    reset = 0; q_m_ack = 0; data_m_access = 0;
    cycle();
    chk("rst_access_low", 32'(s_acc), 32'd0);
    chk("rst_total_dack", 32'(n_dack), 32'd0);

    // Spurious ack while idle, then read data routing to the instruction side.
    q_m_ack = 1; q_m_data_in = 16'h1234;
    cycle();
    chk("spurious_iack", 32'(s_iack), 32'd0);
    chk("spurious_dack", 32'(s_dack), 32'd0);
    q_m_ack = 0; instr_m_access = 1; instr_m_addr = 19'h00042;
    cycle();
    cycle();
    chk("route_instr_din", 32'(s_idin), 32'h1234);
    chk("route_data_din", 32'(s_ddin), 32'd0);
    q_m_ack = 1;
    cycle();
    instr_m_access = 0; q_m_ack = 0;
    cycle();

    // Randomized requesters that hold access until acked, random memory latency and rare resets.
    for (int c = 0; c < 600; c++) begin
      if (s_iack) instr_m_access = 0;
      else if (!instr_m_access && $urandom_range(0, 2) == 0) begin
        instr_m_access = 1;
        instr_m_addr = 19'($urandom);
      end
      if (s_dack) data_m_access = 0;
      else if (!data_m_access && $urandom_range(0, 1) == 0) begin
        data_m_access = 1;
        data_m_addr = 19'($urandom);
        data_m_data_out = 16'($urandom);
        data_m_wr_en = 1'($urandom);
        data_m_bytesel = 2'($urandom);
      end
      q_m_ack = ($urandom_range(0, 2) == 0);
      q_m_data_in = 16'($urandom);
      reset = ($urandom_range(0, 79) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive data grants after which a waiting instruction request wins.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 instr_m_addr  in  19 [19:1]  instruction word address.
REQ-005 instr_m_access  in  1  instruction read request, held until ack.
REQ-006 instr_m_data_in  out  16  read data to instruction requester.
REQ-007 instr_m_ack  out  1  instruction transaction complete.
REQ-008 data_m_addr  in  19 [19:1]  data word address.
REQ-009 data_m_data_out  in  16  write data from data requester.
REQ-010 data_m_access  in  1  data request, held until ack.
REQ-011 data_m_wr_en  in  1  data write (1) / read (0).
REQ-012 data_m_bytesel  in  2  data byte lanes.
REQ-013 data_m_data_in  out  16  read data to data requester.
REQ-014 data_m_ack  out  1  data transaction complete.
REQ-015 q_m_addr  out  19 [19:1], q_m_data_out out 16, q_m_access out 1, q_m_wr_en out 1, q_m_bytesel out 2: shared memory port request side.
REQ-016 q_m_data_in  in  16, q_m_ack  in  1: shared memory port response side.

Function
REQ-017 States SHALL be IDLE, SERVE_INSTR, SERVE_DATA; state register only; all outputs decoded from state.
REQ-018 IDLE: q_m_access=0, q_m_addr=0, q_m_data_out=0, q_m_wr_en=0, q_m_bytesel=0, both acks 0.
REQ-019 Arbitration occurs only in IDLE; grant is registered; request seen in cycle N yields q_m_access=1 in cycle N+1.
REQ-020 Priority: data wins when both request, except instruction wins when streak counter == STARVE_LIMIT.
REQ-021 SERVE_INSTR: q_m_addr=instr_m_addr, q_m_wr_en=0, q_m_bytesel=2'b11, q_m_data_out=0, q_m_access=1.
REQ-022 SERVE_DATA: q_m_addr/data_out/wr_en/bytesel = data_m_* inputs (combinational pass-through), q_m_access=1.
REQ-023 q_m_ack SHALL be forwarded combinationally only to the granted requester's ack; the other ack stays 0.
REQ-024 q_m_data_in SHALL be forwarded to the granted requester's data_in; the non-granted data_in SHALL be 0.
REQ-025 On q_m_ack in a SERVE state, next state is IDLE (one dead cycle between transactions, guarantees requester deasserts access).
REQ-026 q_m_ack while in IDLE SHALL be ignored.
REQ-027 Grant is held until q_m_ack regardless of requester dropping access (no abort).
REQ-028 Streak counter (width clog2(STARVE_LIMIT+1)): +1 on each data ack while instr_m_access=1, saturating at STARVE_LIMIT; cleared on instruction grant or when instr_m_access=0 in IDLE.

Reset
REQ-029 reset SHALL force state IDLE and streak counter 0 on the next edge; reset during a SERVE state aborts it and no ack is forwarded while reset=1.
REQ-030 Outputs SHALL equal IDLE values from the cycle following reset assertion.

Structure
REQ-031 State enum (IDLE, SERVE_INSTR, SERVE_DATA) SHALL live in the shared core package.
REQ-032 Single module; no sub-module; counter and FSM in one always_ff, output decode in one always_comb.

Verification
REQ-033 Instr only, addr 19'h00100, ack after 3 cycles -> q_m_access at N+1, q_m_bytesel=11, instr_m_ack once, data_m_ack never.
REQ-034 Both request same cycle, streak 0 -> data served first, then IDLE cycle, then instr; data write 16'hBEEF bytesel 01 appears on q_m.
REQ-035 Data requests back-to-back with instr held, STARVE_LIMIT=4 -> exactly 4 data grants, then instr granted, counter cleared.
REQ-036 Reset asserted mid SERVE_DATA before ack -> q_m_access=0 next cycle, no data_m_ack, state IDLE.
REQ-037 Spurious q_m_ack in IDLE -> no requester ack; q_m_data_in=16'h1234 during SERVE_INSTR -> instr_m_data_in=16'h1234, data_m_data_in=0.
